exception_ctrl: RTL

//  Initiator side of the CP0 exception-entry/ERET interface. Collects external interrupt lines and

---
 rtl/minisys_exc_pkg.sv | 37 +++
 rtl/irq_sync_edge.sv | 28 ++
 rtl/exception_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/minisys_exc_pkg.sv
// Shared constants and types for the exception-entry / ERET initiator.
package minisys_exc_pkg;

  // CP0 ExcCode values used by the pipeline
  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_BP  = 5'd9;
  localparam logic [4:0] EXC_RI  = 5'd10;
  localparam logic [4:0] EXC_OV  = 5'd12;

  // Common handler entry point
  localparam logic [31:0] DEFAULT_HANDLER_ADDR = 32'h0000_F000;

  // Controller sequencing states
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FLUSH    = 3'd1,
    ST_ENTRY    = 3'd2,
    ST_REDIRECT = 3'd3,
    ST_ERET     = 3'd4
  } exc_state_t;

  // Index of the lowest set bit (0 when none is set; callers qualify with |vec)
  function automatic logic [2:0] lowest_set(input logic [7:0] vec);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (vec[i]) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser for one asynchronous interrupt line plus rising-edge detect.
module irq_sync_edge (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic rise
);

  logic sync1_r;
  logic sync2_r;
  logic prev_r;

  // Bring the line into the clock domain and keep one cycle of history for edge detect
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
    end else begin
      sync1_r <= async_in;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  assign rise = sync2_r & ~prev_r;

endmodule

// File: rtl/exception_ctrl.sv
// Exception-entry / ERET initiator: prioritises WB exceptions, ERET and latched
// interrupts, flushes the pipeline, pulses the CP0 entry write and redirects fetch.
module exception_ctrl
  import minisys_exc_pkg::*;
#(
  parameter int          NUM_IRQ      = 6,
  parameter logic [31:0] HANDLER_ADDR = DEFAULT_HANDLER_ADDR,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               exc_valid,
  input  logic [4:0]         exc_code_in,
  input  logic [31:0]        exc_pc,
  input  logic [31:0]        int_pc,
  input  logic               eret_in,
  input  logic [31:0]        epc_in,
  input  logic               cause_ie,
  output logic               cp0_wen,
  output logic [4:0]         cp0_exc_code,
  output logic [31:0]        cp0_pc,
  output logic               cp0_eret,
  output logic               flush,
  output logic               pc_redirect,
  output logic [31:0]        redirect_pc,
  output logic [NUM_IRQ-1:0] irq_pending,
  output logic [2:0]         irq_taken_id,
  output logic               busy
);

  localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES);

  exc_state_t         state_r;
  logic [2:0]         flush_cnt_r;
  logic [4:0]         code_r;
  logic [31:0]        pc_r;
  logic [NUM_IRQ-1:0] irq_rise_s;
  logic [NUM_IRQ-1:0] pending_r;
  logic [NUM_IRQ-1:0] clear_mask_s;
  logic [7:0]         pend8_s;
  logic [2:0]         irq_sel_s;
  logic               take_irq_s;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
    irq_sync_edge u_sync (
      .clock    (clock),
      .reset    (reset),
      .async_in (irq_in[g]),
      .rise     (irq_rise_s[g])
    );
  end

  // Pick the lowest pending line and decide whether an interrupt is taken this cycle
  always_comb begin
    pend8_s                = 8'h00;
    pend8_s[NUM_IRQ-1:0]   = pending_r;
    irq_sel_s              = lowest_set(pend8_s);
    if ((state_r == ST_IDLE) && !exc_valid && !eret_in && cause_ie && (pending_r != '0)) begin
      take_irq_s = 1'b1;
    end else begin
      take_irq_s = 1'b0;
    end
    for (int i = 0; i < NUM_IRQ; i++) begin
      clear_mask_s[i] = take_irq_s && (irq_sel_s == 3'(i));
    end
  end

  // Pending interrupts: a new edge wins over the clear of a line being taken
  always_ff @(posedge clock) begin
    if (reset) begin
      pending_r <= '0;
    end else begin
      pending_r <= (pending_r & ~clear_mask_s) | irq_rise_s;
    end
  end

  assign irq_pending = pending_r;

  // Sequencing FSM; all strobes are registered and set on the transition into their state
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      flush_cnt_r  <= 3'd0;
      code_r       <= 5'd0;
      pc_r         <= 32'd0;
      cp0_wen      <= 1'b0;
      cp0_exc_code <= 5'd0;
      cp0_pc       <= 32'd0;
      cp0_eret     <= 1'b0;
      flush        <= 1'b0;
      pc_redirect  <= 1'b0;
      redirect_pc  <= 32'd0;
      irq_taken_id <= 3'd0;
      busy         <= 1'b0;
    end else begin
      cp0_wen     <= 1'b0;
      cp0_eret    <= 1'b0;
      pc_redirect <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          flush_cnt_r <= 3'd1;
          if (exc_valid) begin
            code_r  <= exc_code_in;
            pc_r    <= exc_pc;
            state_r <= ST_FLUSH;
            flush   <= 1'b1;
            busy    <= 1'b1;
          end else if (eret_in) begin
            state_r     <= ST_ERET;
            cp0_eret    <= 1'b1;
            pc_redirect <= 1'b1;
            redirect_pc <= epc_in;
            flush       <= 1'b1;
            busy        <= 1'b1;
          end else if (take_irq_s) begin
            code_r       <= EXC_INT;
            pc_r         <= int_pc;
            irq_taken_id <= irq_sel_s;
            state_r      <= ST_FLUSH;
            flush        <= 1'b1;
            busy         <= 1'b1;
          end else begin
            flush <= 1'b0;
            busy  <= 1'b0;
          end
        end
        ST_FLUSH: begin
          if (flush_cnt_r >= FLUSH_LAST) begin
            state_r      <= ST_ENTRY;
            cp0_wen      <= 1'b1;
            cp0_exc_code <= code_r;
            cp0_pc       <= pc_r;
          end else begin
            flush_cnt_r <= flush_cnt_r + 3'd1;
          end
        end
        ST_ENTRY: begin
          state_r     <= ST_REDIRECT;
          pc_redirect <= 1'b1;
          redirect_pc <= HANDLER_ADDR;
        end
        ST_REDIRECT: begin
          state_r <= ST_IDLE;
          flush   <= 1'b0;
          busy    <= 1'b0;
        end
        ST_ERET: begin
          state_r <= ST_IDLE;
          flush   <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          flush   <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
